// File: rtl/mem_access_unit.sv
// MEM-stage responder: loads, stores, LR/SC and AMOs over a req/gnt bus.
// Holds the pipeline through mem_not_ready_o until the result is ready.
module mem_access_unit #(
    parameter bit RESV_EN = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load_i,
    input  logic        store_i,
    input  logic        rva_valid_i,
    input  logic [2:0]  funct3_i,
    input  logic [4:0]  funct5_i,
    input  logic [63:0] addr_i,
    input  logic [63:0] sdata_i,
    input  logic        wen_i,
    input  logic [4:0]  rd_i,
    input  logic        stall_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [63:0] mem_addr_o,
    output logic [63:0] mem_wdata_o,
    output logic [7:0]  mem_wmask_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [63:0] mem_rdata_i,
    output logic [63:0] result_o,
    output logic        wen_o,
    output logic [4:0]  rd_o,
    output logic        exception_o,
    output logic [63:0] cause_o,
    output logic        mem_not_ready_o
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RESP,
        AREQ,
        DONE
    } state_e;

    localparam logic [4:0] F5_ADD  = 5'b00000;
    localparam logic [4:0] F5_SWAP = 5'b00001;
    localparam logic [4:0] F5_LR   = 5'b00010;
    localparam logic [4:0] F5_SC   = 5'b00011;
    localparam logic [4:0] F5_XOR  = 5'b00100;
    localparam logic [4:0] F5_OR   = 5'b01000;
    localparam logic [4:0] F5_AND  = 5'b01100;
    localparam logic [4:0] F5_MIN  = 5'b10000;
    localparam logic [4:0] F5_MAX  = 5'b10100;
    localparam logic [4:0] F5_MINU = 5'b11000;
    localparam logic [4:0] F5_MAXU = 5'b11100;

    state_e      state_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic        resv_valid_q;
    logic [60:0] resv_addr_q;
    logic [63:0] rdata_q;
    logic [63:0] result_q;
    logic        wen_q;
    logic        exc_q;
    logic [63:0] cause_q;

    logic        access;
    logic        is_lr;
    logic        is_sc;
    logic        is_amo;
    logic        is_read_kind;
    logic        write_first;
    logic        misaligned;
    logic        resv_hit;
    logic        wr_hit;
    logic [5:0]  lane_sh;
    logic [7:0]  size_mask;
    logic [63:0] st_wdata;
    logic [63:0] ld_data;
    logic [31:0] old32;
    logic [63:0] a_s;
    logic [63:0] a_u;
    logic [63:0] b_s;
    logic [63:0] b_u;
    logic [63:0] amo_new;
    logic [63:0] amo_wdata;

    function automatic logic [63:0] extract(
        input logic [63:0] d,
        input logic [2:0]  f3,
        input logic [5:0]  sh
    );
        logic [63:0] s;
        s = d >> sh;
        unique case (f3)
            3'd0:    extract = {{56{s[7]}}, s[7:0]};
            3'd1:    extract = {{48{s[15]}}, s[15:0]};
            3'd2:    extract = {{32{s[31]}}, s[31:0]};
            3'd4:    extract = {56'b0, s[7:0]};
            3'd5:    extract = {48'b0, s[15:0]};
            3'd6:    extract = {32'b0, s[31:0]};
            default: extract = s;
        endcase
    endfunction

    assign access       = load_i | store_i | rva_valid_i;
    assign is_lr        = rva_valid_i & (funct5_i == F5_LR);
    assign is_sc        = rva_valid_i & (funct5_i == F5_SC);
    assign is_amo       = rva_valid_i & ~is_lr & ~is_sc;
    assign is_read_kind = (load_i & ~rva_valid_i) | is_lr;
    assign write_first  = (store_i & ~rva_valid_i) | is_sc;
    assign lane_sh      = {addr_i[2:0], 3'b000};

    assign wr_hit   = resv_valid_q && (resv_addr_q == addr_i[63:3]);
    assign resv_hit = RESV_EN && wr_hit;

    always_comb begin
        size_mask  = 8'hFF;
        misaligned = 1'b0;
        unique case (funct3_i[1:0])
            2'd0: begin
                size_mask  = 8'h01;
                misaligned = 1'b0;
            end
            2'd1: begin
                size_mask  = 8'h03;
                misaligned = addr_i[0];
            end
            2'd2: begin
                size_mask  = 8'h0F;
                misaligned = |addr_i[1:0];
            end
            default: begin
                size_mask  = 8'hFF;
                misaligned = |addr_i[2:0];
            end
        endcase
    end

    assign st_wdata = sdata_i << lane_sh;
    assign ld_data  = extract(mem_rdata_i, funct3_i, lane_sh);

    // W ops: signed ops see sign-extended words, unsigned ops zero-extended.
    always_comb begin
        old32 = addr_i[2] ? rdata_q[63:32] : rdata_q[31:0];
        if (funct3_i[0]) begin
            a_s = rdata_q;
            a_u = rdata_q;
            b_s = sdata_i;
            b_u = sdata_i;
        end else begin
            a_s = {{32{old32[31]}}, old32};
            a_u = {32'b0, old32};
            b_s = {{32{sdata_i[31]}}, sdata_i[31:0]};
            b_u = {32'b0, sdata_i[31:0]};
        end
        unique case (funct5_i)
            F5_SWAP: amo_new = b_s;
            F5_ADD:  amo_new = a_s + b_s;
            F5_XOR:  amo_new = a_s ^ b_s;
            F5_AND:  amo_new = a_s & b_s;
            F5_OR:   amo_new = a_s | b_s;
            F5_MIN:  amo_new = ($signed(a_s) < $signed(b_s)) ? a_s : b_s;
            F5_MAX:  amo_new = ($signed(a_s) > $signed(b_s)) ? a_s : b_s;
            F5_MINU: amo_new = (a_u < b_u) ? a_u : b_u;
            F5_MAXU: amo_new = (a_u > b_u) ? a_u : b_u;
            default: amo_new = b_s;
        endcase
        if (!funct3_i[0]) begin
            amo_new[63:32] = 32'b0;
        end
    end

    assign amo_wdata = amo_new << lane_sh;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            resv_valid_q <= 1'b0;
            resv_addr_q  <= '0;
            rdata_q      <= '0;
            result_q     <= '0;
            wen_q        <= 1'b0;
            exc_q        <= 1'b0;
            cause_q      <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (access) begin
                        wen_q    <= wen_i;
                        result_q <= '0;
                        if (misaligned) begin
                            state_q <= DONE;
                            wen_q   <= 1'b0;
                            exc_q   <= 1'b1;
                            cause_q <= is_read_kind ? 64'd4 : 64'd6;
                        end else if (is_sc && !resv_hit) begin
                            state_q      <= DONE;
                            result_q     <= 64'd1;
                            resv_valid_q <= 1'b0;
                        end else begin
                            state_q   <= REQ;
                            mem_req_q <= 1'b1;
                            mem_we_q  <= write_first;
                            if (is_sc) begin
                                resv_valid_q <= 1'b0;
                            end
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt_i) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        if (mem_we_q) begin
                            state_q <= DONE;
                            if (wr_hit) begin
                                resv_valid_q <= 1'b0;
                            end
                        end else begin
                            state_q <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (mem_rvalid_i) begin
                        rdata_q  <= mem_rdata_i;
                        result_q <= ld_data;
                        if (is_amo) begin
                            state_q   <= AREQ;
                            mem_req_q <= 1'b1;
                            mem_we_q  <= 1'b1;
                        end else begin
                            state_q <= DONE;
                        end
                        if (is_lr && RESV_EN) begin
                            resv_valid_q <= 1'b1;
                            resv_addr_q  <= addr_i[63:3];
                        end
                    end
                end
                AREQ: begin
                    if (mem_gnt_i) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        state_q   <= DONE;
                        if (wr_hit) begin
                            resv_valid_q <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    if (!stall_i) begin
                        state_q <= IDLE;
                        exc_q   <= 1'b0;
                        cause_q <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req_o       = mem_req_q;
    assign mem_we_o        = mem_we_q;
    assign mem_addr_o      = {addr_i[63:3], 3'b000};
    assign mem_wdata_o     = (state_q == AREQ) ? amo_wdata : st_wdata;
    assign mem_wmask_o     = size_mask << addr_i[2:0];
    assign mem_not_ready_o = access & (state_q != DONE);
    assign result_o        = access ? result_q : addr_i;
    assign wen_o           = access ? ((state_q == DONE) & wen_q) : wen_i;
    assign rd_o            = rd_i;
    assign exception_o     = exc_q;
    assign cause_o         = cause_q;

endmodule
